// File: rtl/alu_share_arbiter_if.sv
// Dual-lane request/response bundle between issue logic, the shared-ALU arbiter and the ALU itself.
interface alu_share_arbiter_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int SEL_WIDTH   = 4,
  parameter int SHAMT_WIDTH = 5
);
  logic                     flush;
  logic [1:0]               req_valid;
  logic [1:0]               req_ready;
  logic [2*SEL_WIDTH-1:0]   req_op;
  logic [2*DATA_WIDTH-1:0]  req_a;
  logic [2*DATA_WIDTH-1:0]  req_b;
  logic [2*SHAMT_WIDTH-1:0] req_shamt;
  logic [SEL_WIDTH-1:0]     alu_op;
  logic [DATA_WIDTH-1:0]    alu_a;
  logic [DATA_WIDTH-1:0]    alu_b;
  logic [SHAMT_WIDTH-1:0]   alu_shamt;
  logic [DATA_WIDTH-1:0]    alu_result;
  logic                     alu_zero;
  logic [1:0]               rsp_valid;
  logic [1:0]               rsp_ready;
  logic [2*DATA_WIDTH-1:0]  rsp_result;
  logic [1:0]               rsp_zero;
  logic [1:0]               rsp_err;

  modport slave (
    input  flush, req_valid, req_op, req_a, req_b, req_shamt,
           alu_result, alu_zero, rsp_ready,
    output req_ready, alu_op, alu_a, alu_b, alu_shamt,
           rsp_valid, rsp_result, rsp_zero, rsp_err
  );

  modport master (
    output flush, req_valid, req_op, req_a, req_b, req_shamt,
           alu_result, alu_zero, rsp_ready,
    input  req_ready, alu_op, alu_a, alu_b, alu_shamt,
           rsp_valid, rsp_result, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two lanes: registered issue stage,
// result capture one edge later into a 1-entry response buffer per lane.
module alu_share_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int SEL_WIDTH   = 4,
  parameter int SHAMT_WIDTH = 5
) (
  input logic                clk,
  input logic                rst,
  alu_share_arbiter_if.slave bus
);
  logic                   rr_ptr;
  logic                   ex_valid;
  logic                   ex_id;
  logic                   ex_err;
  logic [SEL_WIDTH-1:0]   ex_op;
  logic [DATA_WIDTH-1:0]  ex_a;
  logic [DATA_WIDTH-1:0]  ex_b;
  logic [SHAMT_WIDTH-1:0] ex_shamt;

  logic [1:0]              rsp_valid;
  logic [2*DATA_WIDTH-1:0] rsp_result;
  logic [1:0]              rsp_zero;
  logic [1:0]              rsp_err;

  logic [SEL_WIDTH-1:0]   op_l [2];
  logic [DATA_WIDTH-1:0]  a_l  [2];
  logic [DATA_WIDTH-1:0]  b_l  [2];
  logic [SHAMT_WIDTH-1:0] sh_l [2];
  logic [1:0]             free;
  logic [1:0]             cand;
  logic [1:0]             grant;
  logic [1:0]             ready;
  logic                   acc;
  logic                   acc_id;

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      op_l[i] = bus.req_op[i*SEL_WIDTH +: SEL_WIDTH];
      a_l[i]  = bus.req_a[i*DATA_WIDTH +: DATA_WIDTH];
      b_l[i]  = bus.req_b[i*DATA_WIDTH +: DATA_WIDTH];
      sh_l[i] = bus.req_shamt[i*SHAMT_WIDTH +: SHAMT_WIDTH];
      // A lane stays busy from accept until its response is taken
      free[i] = !(ex_valid && (ex_id == i[0])) && !rsp_valid[i];
    end
    cand  = bus.req_valid & free;
    grant = cand;
    if (cand == 2'b11)
      grant = rr_ptr ? 2'b10 : 2'b01;
    ready  = (rst && !bus.flush) ? grant : 2'b00;
    acc    = |(bus.req_valid & ready);
    acc_id = ready[1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr     <= 1'b0;
      ex_valid   <= 1'b0;
      ex_id      <= 1'b0;
      ex_err     <= 1'b0;
      ex_op      <= '0;
      ex_a       <= '0;
      ex_b       <= '0;
      ex_shamt   <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_zero   <= '0;
      rsp_err    <= '0;
    end else if (bus.flush) begin
      ex_valid  <= 1'b0;
      rsp_valid <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++)
        if (rsp_valid[i] && bus.rsp_ready[i])
          rsp_valid[i] <= 1'b0;
      // The capturing lane is never the lane being drained, so these never collide
      if (ex_valid) begin
        rsp_valid[ex_id]                            <= 1'b1;
        rsp_result[ex_id*DATA_WIDTH +: DATA_WIDTH]  <= bus.alu_result;
        rsp_zero[ex_id]                             <= bus.alu_zero;
        rsp_err[ex_id]                              <= ex_err;
      end
      ex_valid <= acc;
      if (acc) begin
        ex_id    <= acc_id;
        ex_op    <= op_l[acc_id];
        ex_a     <= a_l[acc_id];
        ex_b     <= b_l[acc_id];
        ex_shamt <= sh_l[acc_id];
        ex_err   <= op_l[acc_id] > SEL_WIDTH'(8);
        rr_ptr   <= ~acc_id;
      end
    end
  end

  assign bus.req_ready  = ready;
  assign bus.alu_op     = ex_op;
  assign bus.alu_a      = ex_a;
  assign bus.alu_b      = ex_b;
  assign bus.alu_shamt  = ex_shamt;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_result = rsp_result;
  assign bus.rsp_zero   = rsp_zero;
  assign bus.rsp_err    = rsp_err;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: vector table for arbitration/latency plus hand sequences
// for backpressure, flush and asynchronous reset.
module tb_alu_share_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.DATA_WIDTH(32), .SEL_WIDTH(4), .SHAMT_WIDTH(5)) bus ();

  alu_share_arbiter #(.DATA_WIDTH(32), .SEL_WIDTH(4), .SHAMT_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model of the external combinational ALU
  logic [31:0] alu_r;
  always_comb begin
    alu_r = '0;
    case (bus.alu_op)
      4'd0: alu_r = bus.alu_a + bus.alu_b;
      4'd1: alu_r = bus.alu_a - bus.alu_b;
      4'd2: alu_r = bus.alu_a & bus.alu_b;
      4'd3: alu_r = bus.alu_a | bus.alu_b;
      4'd4: alu_r = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
      4'd5: alu_r = bus.alu_a ^ bus.alu_b;
      4'd6: alu_r = ~(bus.alu_a | bus.alu_b);
      4'd7: alu_r = bus.alu_a << bus.alu_shamt;
      4'd8: alu_r = bus.alu_a >> bus.alu_shamt;
      default: alu_r = '0;
    endcase
    bus.alu_result = alu_r;
    bus.alu_zero   = (alu_r == 32'd0);
  end

  typedef struct {
    logic [1:0]  valid;
    logic [3:0]  op0;
    logic [31:0] a0, b0;
    logic [3:0]  op1;
    logic [31:0] a1, b1;
    logic [4:0]  sh1;
    logic [1:0]  rdy;
    logic [1:0]  e_ready, e_rv;
    logic [31:0] e_r0, e_r1;
    logic [1:0]  e_z, e_e;
    logic [3:0]  e_op;
    logic [31:0] e_a, e_b;
  } vec_t;

  localparam logic [31:0] M1 = 32'hFFFF_FFFF;
  vec_t vt [13];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [3:0] o0, input logic [31:0] a0,
                       input logic [31:0] b0, input logic [3:0] o1, input logic [31:0] a1,
                       input logic [31:0] b1, input logic [4:0] s1, input logic [1:0] rdy,
                       input logic fl);
    bus.req_valid = v;
    bus.req_op    = {o1, o0};
    bus.req_a     = {a1, a0};
    bus.req_b     = {b1, b0};
    bus.req_shamt = {s1, 5'd0};
    bus.rsp_ready = rdy;
    bus.flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // L0 SUB 9-9 vs L1 SLT -1<1, then L0 ADD 5+7, then L0 undefined op 0xF
    vt[0]  = '{2'b11, 4'd1, 32'd9, 32'd9, 4'd4, M1, 32'd1, 5'd0, 2'b11, 2'b01, 2'b00, 32'd0,  32'd0, 2'b00, 2'b00, 4'd1, 32'd9, 32'd9};
    vt[1]  = '{2'b11, 4'd1, 32'd9, 32'd9, 4'd4, M1, 32'd1, 5'd0, 2'b11, 2'b10, 2'b01, 32'd0,  32'd0, 2'b01, 2'b00, 4'd4, M1,    32'd1};
    vt[2]  = '{2'b11, 4'd1, 32'd9, 32'd9, 4'd4, M1, 32'd1, 5'd0, 2'b11, 2'b00, 2'b10, 32'd0,  32'd1, 2'b01, 2'b00, 4'd4, M1,    32'd1};
    vt[3]  = '{2'b11, 4'd1, 32'd9, 32'd9, 4'd4, M1, 32'd1, 5'd0, 2'b11, 2'b01, 2'b00, 32'd0,  32'd1, 2'b01, 2'b00, 4'd1, 32'd9, 32'd9};
    vt[4]  = '{2'b11, 4'd1, 32'd9, 32'd9, 4'd4, M1, 32'd1, 5'd0, 2'b11, 2'b10, 2'b01, 32'd0,  32'd1, 2'b01, 2'b00, 4'd4, M1,    32'd1};
    vt[5]  = '{2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 5'd0, 2'b11, 2'b00, 2'b10, 32'd0,  32'd1, 2'b01, 2'b00, 4'd4, M1,    32'd1};
    vt[6]  = '{2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 5'd0, 2'b11, 2'b00, 2'b00, 32'd0,  32'd1, 2'b01, 2'b00, 4'd4, M1,    32'd1};
    vt[7]  = '{2'b01, 4'd0, 32'd5, 32'd7, 4'd0, 32'd0, 32'd0, 5'd0, 2'b11, 2'b01, 2'b00, 32'd0,  32'd1, 2'b01, 2'b00, 4'd0, 32'd5, 32'd7};
    vt[8]  = '{2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 5'd0, 2'b11, 2'b00, 2'b01, 32'd12, 32'd1, 2'b00, 2'b00, 4'd0, 32'd5, 32'd7};
    vt[9]  = '{2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 5'd0, 2'b11, 2'b00, 2'b00, 32'd12, 32'd1, 2'b00, 2'b00, 4'd0, 32'd5, 32'd7};
    vt[10] = '{2'b01, 4'hF, 32'd3, 32'd3, 4'd0, 32'd0, 32'd0, 5'd0, 2'b11, 2'b01, 2'b00, 32'd12, 32'd1, 2'b00, 2'b00, 4'hF, 32'd3, 32'd3};
    vt[11] = '{2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 5'd0, 2'b11, 2'b00, 2'b01, 32'd0,  32'd1, 2'b01, 2'b01, 4'hF, 32'd3, 32'd3};
    vt[12] = '{2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 5'd0, 2'b11, 2'b00, 2'b00, 32'd0,  32'd1, 2'b01, 2'b01, 4'hF, 32'd3, 32'd3};

    drive(2'b11, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 5'd0, 2'b00, 1'b0);
    #1;
    chk("reset req_ready", bus.req_ready, 2'b00);
    chk("reset rsp_valid", bus.rsp_valid, 2'b00);
    chk("reset rsp_result", bus.rsp_result, 64'd0);
    chk("reset alu_op", bus.alu_op, 4'd0);
    tick();
    rst = 1'b1;
    drive(2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 5'd0, 2'b11, 1'b0);
    #1;

    for (int i = 0; i < 13; i++) begin
      drive(vt[i].valid, vt[i].op0, vt[i].a0, vt[i].b0, vt[i].op1, vt[i].a1, vt[i].b1,
            vt[i].sh1, vt[i].rdy, 1'b0);
      #1;
      chk($sformatf("v%0d req_ready", i), bus.req_ready, vt[i].e_ready);
      tick();
      chk($sformatf("v%0d rsp_valid", i), bus.rsp_valid, vt[i].e_rv);
      chk($sformatf("v%0d rsp_result0", i), bus.rsp_result[31:0], vt[i].e_r0);
      chk($sformatf("v%0d rsp_result1", i), bus.rsp_result[63:32], vt[i].e_r1);
      chk($sformatf("v%0d rsp_zero", i), bus.rsp_zero, vt[i].e_z);
      chk($sformatf("v%0d rsp_err", i), bus.rsp_err, vt[i].e_e);
      chk($sformatf("v%0d alu_op", i), bus.alu_op, vt[i].e_op);
      chk($sformatf("v%0d alu_a", i), bus.alu_a, vt[i].e_a);
      chk($sformatf("v%0d alu_b", i), bus.alu_b, vt[i].e_b);
    end

    // Lane1 SLL 1<<31 held under backpressure, then a follow-up ADD once drained
    drive(2'b10, 4'd0, 32'd0, 32'd0, 4'd7, 32'd1, 32'd0, 5'd31, 2'b01, 1'b0);
    #1;
    chk("sll req_ready", bus.req_ready, 2'b10);
    tick();
    chk("sll alu_op", bus.alu_op, 4'd7);
    chk("sll alu_shamt", bus.alu_shamt, 5'd31);
    drive(2'b10, 4'd0, 32'd0, 32'd0, 4'd0, 32'd2, 32'd2, 5'd0, 2'b01, 1'b0);
    #1;
    chk("sll inflight ready", bus.req_ready, 2'b00);
    tick();
    chk("sll rsp_valid", bus.rsp_valid, 2'b10);
    chk("sll rsp_result1", bus.rsp_result[63:32], 32'h8000_0000);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d req_ready", k), bus.req_ready, 2'b00);
      tick();
      chk($sformatf("bp%0d rsp_valid", k), bus.rsp_valid, 2'b10);
      chk($sformatf("bp%0d rsp_result1", k), bus.rsp_result[63:32], 32'h8000_0000);
    end
    bus.rsp_ready = 2'b11;
    #1;
    chk("drain req_ready", bus.req_ready, 2'b00);
    tick();
    chk("drain rsp_valid", bus.rsp_valid, 2'b00);
    chk("post-drain req_ready", bus.req_ready, 2'b10);
    tick();
    bus.req_valid = 2'b00;
    tick();
    chk("add rsp_valid", bus.rsp_valid, 2'b10);
    chk("add rsp_result1", bus.rsp_result[63:32], 32'd4);
    tick();

    // Flush one cycle after a lane1 accept
    drive(2'b10, 4'd0, 32'd0, 32'd0, 4'd0, 32'd10, 32'd20, 5'd0, 2'b11, 1'b0);
    #1;
    chk("fl accept ready", bus.req_ready, 2'b10);
    tick();
    drive(2'b01, 4'd0, 32'd1, 32'd1, 4'd0, 32'd10, 32'd20, 5'd0, 2'b11, 1'b1);
    #1;
    chk("fl req_ready", bus.req_ready, 2'b00);
    tick();
    chk("fl rsp_valid", bus.rsp_valid, 2'b00);
    chk("fl rsp_result1", bus.rsp_result[63:32], 32'd4);
    drive(2'b11, 4'd0, 32'd1, 32'd1, 4'd0, 32'd10, 32'd20, 5'd0, 2'b11, 1'b0);
    #1;
    chk("fl rr ready", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = 2'b00;
    tick();
    chk("fl next rsp_valid", bus.rsp_valid, 2'b01);
    chk("fl next rsp_result0", bus.rsp_result[31:0], 32'd2);
    tick();
    chk("fl drained", bus.rsp_valid, 2'b00);

    // Reset with lane0 in flight and lane1 response pending
    drive(2'b10, 4'd0, 32'd0, 32'd0, 4'd0, 32'd3, 32'd4, 5'd0, 2'b00, 1'b0);
    #1;
    chk("rst l1 ready", bus.req_ready, 2'b10);
    tick();
    drive(2'b01, 4'd1, 32'd8, 32'd3, 4'd0, 32'd3, 32'd4, 5'd0, 2'b00, 1'b0);
    #1;
    chk("rst l0 ready", bus.req_ready, 2'b01);
    tick();
    chk("pre-rst rsp_valid", bus.rsp_valid, 2'b10);
    chk("pre-rst rsp_result1", bus.rsp_result[63:32], 32'd7);
    #2;
    rst = 1'b0;
    #1;
    bus.req_valid = 2'b11;
    #1;
    chk("arst rsp_valid", bus.rsp_valid, 2'b00);
    chk("arst rsp_result", bus.rsp_result, 64'd0);
    chk("arst rsp_zero", bus.rsp_zero, 2'b00);
    chk("arst rsp_err", bus.rsp_err, 2'b00);
    chk("arst alu", {bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_shamt}, 64'd0);
    chk("arst req_ready", bus.req_ready, 2'b00);
    #2;
    rst = 1'b1;
    #1;
    chk("post-rst grant", bus.req_ready, 2'b01);
    tick();
    chk("post-rst alu_op", bus.alu_op, 4'd1);
    chk("post-rst alu_a", bus.alu_a, 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
